// File: rtl/div_seq.sv
// Sequential restoring divider with signed/unsigned modes.
//
// A start accepted in IDLE or DONE captures the operands. Each of the next WIDTH rising
// edges performs one shift-subtract step on the operand magnitudes. The signed result is
// then written to the result registers and done pulses for one cycle.
// A zero divisor skips iteration: it completes on the next edge with y = all ones,
// y_hi = a and div_by_zero = 1.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request to begin a division (ignored while busy)
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   a, b         dividend, divisor
//   busy         high while iterating
//   done         one-cycle pulse when y/y_hi/div_by_zero hold a new result
//   y            quotient (LO)
//   y_hi         remainder (HI)
//   div_by_zero  set with done when the divisor was zero
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   dvs_q;       // divisor magnitude
  logic [WIDTH-1:0]   quo_q;       // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH:0]     rem_q;       // partial remainder, one guard bit for the trial subtract
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_hi_q;
  logic               dbz_q;

  // Operand magnitudes at capture time
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One restoring iteration
  logic [WIDTH:0]   rem_sh, diff, rem_nx;
  logic [WIDTH-1:0] quo_nx, quo_fin, rem_fin;

  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    // rem_sh < 2*dvs, so the guard bit of diff is set exactly when the subtract underflows
    rem_nx = diff[WIDTH] ? rem_sh : diff;
    quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    // Truncation toward zero: quotient negated on sign mismatch, remainder follows dividend.
    // -2^WIDTH-1 / -1 gives magnitude 2^WIDTH-1 unnegated, i.e. the most negative value.
    quo_fin = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_fin = neg_rem_q ? (~rem_nx[WIDTH-1:0] + 1'b1) : rem_nx[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      y_q       <= '0;
      y_hi_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (b == '0) begin
              state_q <= StDone;
              y_q     <= '1;
              y_hi_q  <= a;
              dbz_q   <= 1'b1;
            end else begin
              // Only working registers load here; the presented result stays put
              state_q   <= StRun;
              cnt_q     <= '0;
              dvs_q     <= b_mag;
              quo_q     <= a_mag;
              rem_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StDone;
            y_q     <= quo_fin;
            y_hi_q  <= rem_fin;
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign y           = y_q;
  assign y_hi        = y_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
`timescale 1ns/1ps
module tb_div_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  // Expected result of the operation in flight, and the result last presented
  logic [W-1:0] exp_q, exp_r;
  logic         exp_dz;
  logic [W-1:0] last_y, last_yh;
  logic         last_dz;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .y           (y),
    .y_hi        (y_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] d, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    longint sx, sd;
    if (d == '0) begin
      q = '1; r = x; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        sx = longint'($signed(x));
        sd = longint'($signed(d));
        q  = W'(sx / sd);
        r  = W'(sx % sd);
      end else begin
        q = x / d;
        r = x % d;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request for one edge; then scrambles the inputs to prove they were captured
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
    ref_div(ta, tbv, ts, exp_q, exp_r, exp_dz);
    a = ta; b = tbv; is_signed = ts; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done, checking latency, busy length and result stability.
  // Returns in the done cycle.
  task automatic finish_op();
    int   cyc = 0;
    int   bcnt = 0;
    logic hold_ok = 1'b1;
    while (done !== 1'b1 && cyc < int'(W) + 4) begin
      if (busy === 1'b1) bcnt++;
      if (y !== last_y || y_hi !== last_yh || div_by_zero !== last_dz) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), exp_dz ? 64'd0 : 64'(W));
    check("busy_cycles", 64'(bcnt), exp_dz ? 64'd0 : 64'(W));
    check("result_hold", 64'(hold_ok), 64'd1);
    check("y", 64'(y), 64'(exp_q));
    check("y_hi", 64'(y_hi), 64'(exp_r));
    check("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
    last_y = exp_q; last_yh = exp_r; last_dz = exp_dz;
  endtask

  task automatic idle_check();
    tick();
    check("done_pulse_end", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
    start_op(ta, tbv, ts);
    finish_op();
    idle_check();
  endtask

  initial begin
    int           pulses;
    logic [W-1:0] got_y, got_yh;
    logic [W-1:0] ra, rb;

    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    last_y = '0; last_yh = '0; last_dz = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_y_hi", 64'(y_hi), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Start accepted on the first edge after reset release; 100/7 unsigned
    do_op(32'd100, 32'd7, 1'b0);
    check("u100_7_y", 64'(last_y), 64'd14);
    check("u100_7_yhi", 64'(last_yh), 64'd2);

    // Signed truncation toward zero
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("s_m7_2_y", 64'(last_y), 64'hFFFF_FFFD);
    check("s_m7_2_yhi", 64'(last_yh), 64'hFFFF_FFFF);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    check("s_7_m2_y", 64'(last_y), 64'hFFFF_FFFD);
    check("s_7_m2_yhi", 64'(last_yh), 64'd1);

    // Divide by zero, then a normal completion must clear the flag
    do_op(32'h1234_5678, 32'd0, 1'b0);
    check("dbz_y", 64'(last_y), 64'hFFFF_FFFF);
    check("dbz_yhi", 64'(last_yh), 64'h1234_5678);
    check("dbz_flag", 64'(last_dz), 64'd1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_y", 64'(last_y), 64'h8000_0000);
    check("ovf_yhi", 64'(last_yh), 64'd0);
    check("ovf_flag", 64'(div_by_zero), 64'd0);

    // Start while busy is ignored
    start_op(32'd1000, 32'd7, 1'b0);
    pulses = 0; got_y = '0; got_yh = '0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      if (i == 5) begin start = 1'b1; a = 32'd9; b = 32'd3; is_signed = 1'b0; end
      if (i == 6) start = 1'b0;
      if (done === 1'b1) begin pulses++; got_y = y; got_yh = y_hi; end
      tick();
    end
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_y", 64'(got_y), 64'd142);
    check("busy_start_yhi", 64'(got_yh), 64'd6);
    check("busy_start_hold", 64'(y), 64'd142);
    last_y = 32'd142; last_yh = 32'd6; last_dz = 1'b0;

    // Back-to-back: new start accepted in the DONE cycle
    start_op(32'h0000_1234, 32'h10, 1'b0);
    finish_op();
    check("b2b_done1", 64'(done), 64'd1);
    start_op(32'hFFFF_FF9C, 32'd3, 1'b1);
    check("b2b_done_1cyc", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    finish_op();
    check("b2b_y2", 64'(last_y), 64'hFFFF_FFDF);
    check("b2b_yhi2", 64'(last_yh), 64'hFFFF_FFFF);
    idle_check();

    // Reset at iteration 10
    start_op(32'd5000, 32'd3, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_y", 64'(y), 64'd0);
    check("mrst_yhi", 64'(y_hi), 64'd0);
    check("mrst_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < int'(W) + 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    check("mrst_no_done", 64'(pulses), 64'd0);
    last_y = '0; last_yh = '0; last_dz = 1'b0;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mrst_after_y", 64'(last_y), 64'd1);
    check("mrst_after_yhi", 64'(last_yh), 64'd0);

    // Randomized operations against the reference
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = {16'h0, 16'($urandom)};
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
